// File: rtl/stream_argmax_accel.sv
// Streaming argmax/argmin reduction engine.
// Accepts a framed burst of signed samples, tracks the extreme value, its
// zero-based position and the beat count, and holds the result until the
// consumer takes it. Beats past 2^IDX_W are accepted but excluded from the
// compare, and they flag overflow.
module stream_argmax_accel #(
  parameter int WIDTH      = 32,
  parameter int IDX_W      = 10,
  parameter bit END_ON_GAP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             data_last,
  input  logic             mode_min,
  output logic             data_ready,
  output logic [WIDTH-1:0] result_value,
  output logic [IDX_W-1:0] result_index,
  output logic [IDX_W:0]   result_count,
  output logic             result_overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W:0]   cnt;
  logic             ovf;
  logic             mode_q;

  logic             accept;
  logic             full;
  logic             better;
  logic             gap_end;
  logic [WIDTH-1:0] nxt_best;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W:0]   nxt_cnt;
  logic             nxt_ovf;

  assign data_ready   = (state != HOLD);
  assign result_valid = (state == HOLD);
  assign accept       = data_valid && data_ready;
  // cnt only ever reaches 2^IDX_W through saturation, so its MSB means "full".
  assign full         = cnt[IDX_W];
  assign better       = mode_q ? ($signed(data_in) < $signed(best))
                               : ($signed(data_in) > $signed(best));
  assign gap_end      = END_ON_GAP && (state == ACCUM) && !data_valid;

  // Running-reduction update that an accepted beat would produce.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    nxt_best = best;
    nxt_idx  = best_idx;
    nxt_cnt  = cnt;
    nxt_ovf  = ovf;
    if (state == IDLE) begin
      nxt_best = data_in;
      nxt_idx  = '0;
      nxt_cnt  = (IDX_W + 1)'(1);
      nxt_ovf  = 1'b0;
    end else if (full) begin
      nxt_ovf = 1'b1;
    end else begin
      if (better) begin
        nxt_best = data_in;
        nxt_idx  = cnt[IDX_W-1:0];
      end
      nxt_cnt = cnt + 1'b1;
    end
  end

  // Burst framing FSM and running best/index/count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      best     <= '0;
      best_idx <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, matching flop behaviour.
      case (state)
        IDLE: begin
          if (accept) begin
            best     <= nxt_best;
            best_idx <= nxt_idx;
            cnt      <= nxt_cnt;
            ovf      <= nxt_ovf;
            mode_q   <= mode_min;
            state    <= data_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            best     <= nxt_best;
            best_idx <= nxt_idx;
            cnt      <= nxt_cnt;
            ovf      <= nxt_ovf;
            if (data_last) state <= HOLD;
          end else if (gap_end) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers: loaded only when a burst completes, stable otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_value    <= '0;
      result_index    <= '0;
      result_count    <= '0;
      result_overflow <= 1'b0;
    end else if (accept && data_last) begin
      result_value    <= nxt_best;
      result_index    <= nxt_idx;
      result_count    <= nxt_cnt;
      result_overflow <= nxt_ovf;
    end else if (gap_end) begin
      result_value    <= best;
      result_index    <= best_idx;
      result_count    <= cnt;
      result_overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_stream_argmax_accel.sv
// Self-checking bench for stream_argmax_accel: directed scenarios on the
// default configuration, randomized bursts against a reference model, plus
// END_ON_GAP=1 and IDX_W=2 instances for gap framing and overflow.
module tb_stream_argmax_accel;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_last;
  logic        mode_min;
  logic        result_ready;

  // default configuration
  logic        a_ready, a_ovf, a_valid;
  logic [31:0] a_value;
  logic [9:0]  a_index;
  logic [10:0] a_count;
  // END_ON_GAP=1
  logic        g_ready, g_ovf, g_valid;
  logic [31:0] g_value;
  logic [9:0]  g_index;
  logic [10:0] g_count;
  // IDX_W=2
  logic        s_ready, s_ovf, s_valid;
  logic [31:0] s_value;
  logic [1:0]  s_index;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] bq[$];

  stream_argmax_accel u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .mode_min(mode_min), .data_ready(a_ready),
    .result_value(a_value), .result_index(a_index), .result_count(a_count),
    .result_overflow(a_ovf), .result_valid(a_valid), .result_ready(result_ready)
  );

  stream_argmax_accel #(.END_ON_GAP(1'b1)) u_gap (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .mode_min(mode_min), .data_ready(g_ready),
    .result_value(g_value), .result_index(g_index), .result_count(g_count),
    .result_overflow(g_ovf), .result_valid(g_valid), .result_ready(result_ready)
  );

  stream_argmax_accel #(.IDX_W(2)) u_small (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .mode_min(mode_min), .data_ready(s_ready),
    .result_value(s_value), .result_index(s_index), .result_count(s_count),
    .result_overflow(s_ovf), .result_valid(s_valid), .result_ready(result_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat; called at a falling edge, returns at the next one.
  task automatic send(input logic [31:0] d, input logic last, input logic mode);
    data_in    = d;
    data_last  = last;
    mode_min   = mode;
    data_valid = 1'b1;
    bq.push_back(d);
    @(negedge clk);
  endtask

  task automatic idle();
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic check_a(input string pfx, input logic [31:0] v, input int idx,
                         input int cnt, input logic ovf);
    check({pfx, "_valid"}, a_valid, 1'b1);
    check({pfx, "_value"}, a_value, v);
    check({pfx, "_index"}, a_index, idx);
    check({pfx, "_count"}, a_count, cnt);
    check({pfx, "_ovf"},   a_ovf,   ovf);
  endtask

  // Reference: extreme over the first 2^idx_w samples with strict compare
  // (earliest index wins ties); count saturates; overflow if more arrived.
  function automatic void model(input int idx_w, input logic mn, output logic [31:0] v,
                                output int idx, output int cnt, output logic ovf);
    int lim = 1 << idx_w;
    v   = bq[0];
    idx = 0;
    for (int i = 1; i < bq.size() && i < lim; i++) begin
      if (mn ? ($signed(bq[i]) < $signed(v)) : ($signed(bq[i]) > $signed(v))) begin
        v   = bq[i];
        idx = i;
      end
    end
    cnt = (bq.size() < lim) ? bq.size() : lim;
    ovf = (bq.size() > lim);
  endfunction

  function automatic logic [31:0] rand_sample();
    int r = int'($urandom_range(0, 3));
    if (r == 0) return $urandom;
    if (r == 1) return ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7fff_ffff;
    return 32'(int'($urandom_range(0, 6)) - 3);
  endfunction

  initial begin
    logic [31:0] ev;
    logic [31:0] prev_v;
    int          ei, ec;
    logic        eo;
    logic        mode;
    int          n, w;

    reset = 1'b0; data_in = '0; data_valid = 1'b0; data_last = 1'b0;
    mode_min = 1'b0; result_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", a_valid, 1'b0);
    check("rst_value", a_value, 32'h0);
    check("rst_index", a_index, 0);
    check("rst_count", a_count, 0);
    check("rst_ovf",   a_ovf,   1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", a_ready, 1'b1);

    // max burst
    send(32'h0080_0000, 1'b0, 1'b0);
    send(32'h0380_0000, 1'b0, 1'b0);
    send(32'h0280_0000, 1'b0, 1'b0);
    send(32'h0180_0000, 1'b1, 1'b0);
    idle();
    check_a("max", 32'h0380_0000, 1, 4, 1'b0);
    @(negedge clk);
    check("max_drop_valid", a_valid, 1'b0);
    check("max_ready_back", a_ready, 1'b1);

    // negative values, max mode
    send(32'hFE00_0000, 1'b0, 1'b0);
    send(32'hFD00_0000, 1'b0, 1'b0);
    send(32'hFC00_0000, 1'b0, 1'b0);
    send(32'hFF00_0000, 1'b1, 1'b0);
    idle();
    check_a("neg_max", 32'hFF00_0000, 3, 4, 1'b0);
    @(negedge clk);
    // min mode
    send(32'hFE00_0000, 1'b0, 1'b1);
    send(32'hFD00_0000, 1'b0, 1'b1);
    send(32'hFC00_0000, 1'b0, 1'b1);
    send(32'hFF00_0000, 1'b1, 1'b1);
    idle();
    check_a("neg_min", 32'hFC00_0000, 2, 4, 1'b0);
    @(negedge clk);
    // mode toggled mid-burst: first beat decides
    send(32'hFE00_0000, 1'b0, 1'b1);
    send(32'hFD00_0000, 1'b0, 1'b0);
    send(32'hFC00_0000, 1'b0, 1'b0);
    send(32'hFF00_0000, 1'b1, 1'b0);
    idle();
    check_a("tog_min", 32'hFC00_0000, 2, 4, 1'b0);
    @(negedge clk);
    send(32'hFE00_0000, 1'b0, 1'b0);
    send(32'hFD00_0000, 1'b0, 1'b1);
    send(32'hFC00_0000, 1'b0, 1'b1);
    send(32'hFF00_0000, 1'b1, 1'b1);
    idle();
    check_a("tog_max", 32'hFF00_0000, 3, 4, 1'b0);
    @(negedge clk);

    // ties, then back-to-back single-beat burst
    send(32'h0200_0000, 1'b0, 1'b0);
    send(32'h0500_0000, 1'b0, 1'b0);
    send(32'h0500_0000, 1'b0, 1'b0);
    send(32'h0100_0000, 1'b1, 1'b0);
    idle();
    check_a("tie", 32'h0500_0000, 1, 4, 1'b0);
    @(negedge clk);
    check("tie_stable_value", a_value, 32'h0500_0000);
    check("tie_stable_index", a_index, 1);
    send(32'h0000_0000, 1'b1, 1'b0);
    idle();
    check_a("single", 32'h0, 0, 1, 1'b0);
    @(negedge clk);

    // backpressure: offered beats during HOLD must not be taken
    result_ready = 1'b0;
    send(32'h10, 1'b0, 1'b0);
    send(32'h20, 1'b0, 1'b0);
    send(32'h30, 1'b0, 1'b0);
    send(32'h40, 1'b1, 1'b0);
    check_a("bp", 32'h40, 3, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      data_in = 32'h7fff_ffff; data_valid = 1'b1; data_last = 1'b0;
      @(negedge clk);
      check("bp_hold_valid", a_valid, 1'b1);
      check("bp_hold_ready", a_ready, 1'b0);
      check("bp_hold_value", a_value, 32'h40);
    end
    idle();
    result_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", a_valid, 1'b0);
    check("bp_release_ready", a_ready, 1'b1);
    check("bp_release_value", a_value, 32'h40);
    send(32'h5, 1'b0, 1'b0);
    send(32'h6, 1'b1, 1'b0);
    idle();
    check_a("bp_next", 32'h6, 1, 2, 1'b0);
    @(negedge clk);

    // randomized bursts against the reference model
    prev_v = a_value;
    result_ready = 1'b0;
    for (int b = 0; b < 40; b++) begin
      n = int'($urandom_range(1, 12));
      mode = 1'($urandom_range(0, 1));
      bq.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(negedge clk);
          check("rnd_stable", a_value, prev_v);
        end
        send(rand_sample(), (i == n - 1), (i == 0) ? mode : 1'($urandom_range(0, 1)));
      end
      idle();
      model(10, mode, ev, ei, ec, eo);
      check_a("rnd", ev, ei, ec, eo);
      w = int'($urandom_range(0, 3));
      for (int k = 0; k < w; k++) begin
        data_valid = 1'b1; data_last = 1'b1;
        @(negedge clk);
        check("rnd_hold_valid", a_valid, 1'b1);
        check("rnd_hold_ready", a_ready, 1'b0);
      end
      idle();
      result_ready = 1'b1;
      @(negedge clk);
      check("rnd_release", a_valid, 1'b0);
      result_ready = 1'b0;
      prev_v = ev;
    end
    result_ready = 1'b1;

    // END_ON_GAP=1: an idle cycle in ACCUM closes the burst
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(32'h0400_0000, 1'b0, 1'b0);
    send(32'h0300_0000, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("gap_valid", g_valid, 1'b1);
    check("gap_value", g_value, 32'h0400_0000);
    check("gap_index", g_index, 0);
    check("gap_count", g_count, 2);
    check("gap_ovf",   g_ovf,   1'b0);
    check("gap_ready", g_ready, 1'b0);

    // IDX_W=2 overflow
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bq.delete();
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b0);
    send(32'd3, 1'b0, 1'b0);
    send(32'd4, 1'b0, 1'b0);
    send(32'd9, 1'b1, 1'b0);
    idle();
    model(2, 1'b0, ev, ei, ec, eo);
    check("ovf_valid", s_valid, 1'b1);
    check("ovf_value", s_value, ev);
    check("ovf_index", s_index, ei);
    check("ovf_count", s_count, ec);
    check("ovf_flag",  s_ovf,   eo);
    check("ovf_spec_value", s_value, 32'd4);
    check("ovf_spec_flag",  s_ovf,   1'b1);
    @(negedge clk);
    check("ovf_drop", s_valid, 1'b0);

    // reset mid-burst clears outputs at once; next burst starts clean
    send(32'd7, 1'b0, 1'b0);
    send(32'd8, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_value", s_value, 32'h0);
    check("mid_rst_index", s_index, 0);
    check("mid_rst_count", s_count, 0);
    check("mid_rst_ovf",   s_ovf,   1'b0);
    check("mid_rst_valid", s_valid, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(32'd5, 1'b0, 1'b0);
    send(32'd6, 1'b1, 1'b0);
    idle();
    check("clean_valid", s_valid, 1'b1);
    check("clean_value", s_value, 32'd6);
    check("clean_index", s_index, 1);
    check("clean_count", s_count, 2);
    check("clean_ovf",   s_ovf,   1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_argmax_accel.md
Name: stream_argmax_accel

Overview:
- Streaming reduction engine that returns the extreme value (max or min) of a burst of signed fixed-point samples, plus that sample's position (argmax/argmin) and the beat count.
- Sits between the DMA/stream front end and the classifier post-processing; it replaces the single-channel running-max accelerator.
- Adds explicit burst framing, min mode, index tracking, result backpressure and overflow reporting.

Parameters:
- WIDTH, 32, sample width; two's-complement, default format Q8.24. The format does not affect the compare.
- IDX_W, 10, index width; maximum burst length is 2^IDX_W beats.
- END_ON_GAP, 0, when 1, a cycle with data_valid=0 in ACCUM also ends the burst (legacy framing).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  sample.
- data_valid  in  1  sample qualifier.
- data_last  in  1  marks the final beat of a burst; qualified by data_valid.
- mode_min  in  1  0 = find max, 1 = find min; sampled on the first beat of a burst.
- data_ready  out  1  the block accepts a beat when data_valid && data_ready.
- result_value  out  WIDTH  extreme value of the last completed burst.
- result_index  out  IDX_W  zero-based position of result_value within its burst.
- result_count  out  IDX_W+1  number of beats accepted in the burst (saturating).
- result_overflow  out  1  burst exceeded 2^IDX_W beats.
- result_valid  out  1  result available.
- result_ready  in  1  result consumer handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All result_* outputs go to 0 and result_valid=0.
  - Internal best, index and count registers clear.
  - After reset releases, data_ready=1.
- data_ready is combinational from state: it is 1 in IDLE and ACCUM, 0 in HOLD.
- IDLE, on an accepted beat:
  - best=data_in, best_idx=0, cnt=1; the block latches mode_min.
  - If data_last=1, go to HOLD; otherwise go to ACCUM.
- ACCUM, on an accepted beat at position p=cnt:
  - Replace best only on a strict signed compare: data_in>best in max mode, data_in<best in min mode.
  - Ties keep the earliest index.
  - cnt increments.
  - data_last=1 ends the burst and the state goes to HOLD.
- END_ON_GAP=1: in ACCUM, data_valid=0 ends the burst with the beats accepted so far. The state goes to HOLD with no extra beat consumed.
- Overflow:
  - Once cnt=2^IDX_W, further beats in the same burst are still accepted but excluded from the compare.
  - cnt saturates at 2^IDX_W and overflow is set.
  - data_last on a dropped beat still ends the burst.
- Entering HOLD:
  - best, best_idx, cnt and overflow are copied into the result_* registers.
  - result_valid rises in the cycle after the final beat is accepted (latency 1 from the last handshake).
  - result_* outputs are stable from then on. They do not change during the next burst until that burst completes.
- HOLD:
  - result_valid=1 until result_ready=1 at a rising edge, then the state returns to IDLE.
  - result_valid drops on that edge; the result_* values stay unchanged.
  - Incoming data_valid is ignored because data_ready=0.
- Single-beat burst (data_valid and data_last together in IDLE): result_index=0, result_count=1.
- mode_min changes mid-burst have no effect.
- data_last without data_valid is ignored.
- Reset asserted mid-burst or in HOLD aborts everything; no result is produced for that burst.
- Arithmetic: the compare is on the full WIDTH, signed; there is no rounding or saturation of values.

Test Plan:
- Max burst, Q8.24 samples 0x00800000, 0x03800000, 0x02800000, 0x01800000, data_last on the 4th, mode_min=0, result_ready=1 -> the cycle after the 4th beat, result_valid=1 with value 0x03800000, index 1, count 4, overflow 0; one cycle later result_valid=0.
- Negative values 0xFE000000, 0xFD000000, 0xFC000000, 0xFF000000:
  - mode_min=0 -> value 0xFF000000, index 3.
  - Same burst with mode_min=1 -> value 0xFC000000, index 2.
  - mode_min toggled mid-burst -> identical results.
- Ties and back-to-back bursts:
  - 0x02000000, 0x05000000, 0x05000000, 0x01000000 -> value 0x05000000, index 1.
  - Next burst 0x00000000 (single beat, last) -> value 0, index 0, count 1.
  - The earlier result_* values stay unchanged during the second burst.
- Backpressure: hold result_ready=0 for 5 cycles after completion -> result_valid stays 1, data_ready=0, offered beats are not counted; on result_ready=1, result_valid drops next edge and data_ready=1.
- END_ON_GAP=1: beats 0x04000000, 0x03000000, then data_valid=0 -> value 0x04000000, index 0, count 2.
- IDX_W=2, beats 1, 2, 3, 4, 9 (last on 9):
  - value 4, index 3, count 4, overflow 1.
  - Separately, reset pulsed low mid-burst -> all outputs 0 immediately, the next burst starts clean.
